// File: rtl/rr_mux_pkg.sv
// -----------------------------------------------------------------------------
// rr_mux_pkg
// Shared declarations for the round-robin multiplexer slice.
//   out_state_e : occupancy of the single output register (EMPTY / FULL).
// -----------------------------------------------------------------------------
package rr_mux_pkg;

   typedef enum logic {
      OUT_EMPTY = 1'b0,
      OUT_FULL  = 1'b1
   } out_state_e;

endpackage : rr_mux_pkg

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick. The scan starts one past the last granted
// index and wraps at NUM_ELEM-1. ptr_i itself is the lowest priority.
// Ports:
//   req_i       [NUM_ELEM-1:0] request vector
//   ptr_i       [IDX_W-1:0]    last granted index
//   en_i                       arbitration enable
//   gnt_idx_o   [IDX_W-1:0]    winning index (0 when no request)
//   gnt_valid_o                a winner exists and en_i is set
// -----------------------------------------------------------------------------
module rr_arbiter
   import rr_mux_pkg::*;
#(
   parameter  int NUM_ELEM = 6,
   localparam int IDX_W    = $clog2(NUM_ELEM)
) (
   input  logic [NUM_ELEM-1:0] req_i,
   input  logic [IDX_W-1:0]    ptr_i,
   input  logic                en_i,
   output logic [IDX_W-1:0]    gnt_idx_o,
   output logic                gnt_valid_o
);

   logic             found;
   logic [IDX_W-1:0] cand;

   // The modulo keeps every candidate below NUM_ELEM. Unused codes of a
   // non-power-of-two width can therefore never be granted.
   always_comb begin
      found     = 1'b0;
      gnt_idx_o = '0;
      cand      = '0;
      for (int off = 1; off <= NUM_ELEM; off++) begin
         cand = IDX_W'((int'(ptr_i) + off) % NUM_ELEM);
         if (!found && req_i[cand]) begin
            found     = 1'b1;
            gnt_idx_o = cand;
         end
      end
      gnt_valid_o = en_i & found;
   end

endmodule : rr_arbiter

// File: rtl/rr_mux.sv
// -----------------------------------------------------------------------------
// rr_mux
// Round-robin gather of NUM_ELEM valid/ready producers into one registered
// valid/ready stream.
// Ports:
//   clk_i, arst_i               clock, asynchronous active-high reset
//   in_data_i   [N][W]          per-channel word
//   in_valid_i  [N]             per-channel request
//   in_ready_o  [N]             per-channel accept (one-hot or zero)
//   out_data_o  [W]             registered selected word
//   out_idx_o   [IDX_W]         source channel of out_data_o
//   out_valid_o                 output register occupied
//   out_ready_i                 consumer accepts
// -----------------------------------------------------------------------------
module rr_mux
   import rr_mux_pkg::*;
#(
   parameter  int NUM_ELEM   = 6,
   parameter  int ELEM_WIDTH = 8,
   localparam int IDX_W      = $clog2(NUM_ELEM)
) (
   input  logic                                 clk_i,
   input  logic                                 arst_i,
   input  logic [NUM_ELEM-1:0][ELEM_WIDTH-1:0]  in_data_i,
   input  logic [NUM_ELEM-1:0]                  in_valid_i,
   output logic [NUM_ELEM-1:0]                  in_ready_o,
   output logic [ELEM_WIDTH-1:0]                out_data_o,
   output logic [IDX_W-1:0]                     out_idx_o,
   output logic                                 out_valid_o,
   input  logic                                 out_ready_i
);

   out_state_e       state_q, state_d;
   logic [IDX_W-1:0] ptr_q;
   logic [IDX_W-1:0] gnt_idx;
   logic             gnt_valid;
   logic             free;
   logic             xfer;

   assign out_valid_o = (state_q == OUT_FULL);

   // The register can take a new word when it is empty or drains this cycle.
   // This allows one word per cycle with no bubble.
   assign free = ~out_valid_o | out_ready_i;

   rr_arbiter #(
      .NUM_ELEM (NUM_ELEM)
   ) u_arb (
      .req_i       (in_valid_i),
      .ptr_i       (ptr_q),
      .en_i        (free),
      .gnt_idx_o   (gnt_idx),
      .gnt_valid_o (gnt_valid)
   );

   // The grant only goes to a requesting channel, so any grant is a transfer.
   assign xfer = free & gnt_valid;

   always_comb begin
      in_ready_o = '0;
      for (int i = 0; i < NUM_ELEM; i++) begin
         in_ready_o[i] = xfer && (gnt_idx == IDX_W'(i));
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         OUT_EMPTY: if (xfer)                 state_d = OUT_FULL;
         OUT_FULL:  if (out_ready_i && !xfer) state_d = OUT_EMPTY;
         default:                             state_d = OUT_EMPTY;
      endcase
   end

   // ---- output register stage ----
   // Reset puts ptr at the top index, so channel 0 is scanned first.
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         state_q    <= OUT_EMPTY;
         ptr_q      <= IDX_W'(NUM_ELEM - 1);
         out_data_o <= '0;
         out_idx_o  <= '0;
      end else begin
         state_q <= state_d;
         if (xfer) begin
            out_data_o <= in_data_i[gnt_idx];
            out_idx_o  <= gnt_idx;
            ptr_q      <= gnt_idx;
         end
      end
   end

endmodule : rr_mux

// File: tb/tb_rr_mux.sv
module tb_rr_mux;

   logic clk = 1'b0;
   logic arst;

   // Instance A: default 6 x 8
   logic [5:0][7:0]  a_data;
   logic [5:0]       a_valid;
   logic [5:0]       a_in_ready;
   logic [7:0]       a_out_data;
   logic [2:0]       a_out_idx;
   logic             a_out_valid;
   logic             a_ordy;

   // Instance B: 5 x 12 for the random run
   logic [4:0][11:0] b_data;
   logic [4:0]       b_valid;
   logic [4:0]       b_in_ready;
   logic [11:0]      b_out_data;
   logic [2:0]       b_out_idx;
   logic             b_out_valid;
   logic             b_ordy;

   int nvec = 0;
   int nerr = 0;

   // Scoreboards
   logic [15:0] a_q [$];
   logic        a_full;
   logic [7:0]  seed [6];
   int          cnt  [6];
   logic [11:0] b_q [5][$];
   int          b_cnt [5];
   logic [4:0]  b_acc;

   rr_mux #(.NUM_ELEM(6), .ELEM_WIDTH(8)) u_dut_a (
      .clk_i(clk), .arst_i(arst),
      .in_data_i(a_data), .in_valid_i(a_valid), .in_ready_o(a_in_ready),
      .out_data_o(a_out_data), .out_idx_o(a_out_idx),
      .out_valid_o(a_out_valid), .out_ready_i(a_ordy)
   );

   rr_mux #(.NUM_ELEM(5), .ELEM_WIDTH(12)) u_dut_b (
      .clk_i(clk), .arst_i(arst),
      .in_data_i(b_data), .in_valid_i(b_valid), .in_ready_o(b_in_ready),
      .out_data_o(b_out_data), .out_idx_o(b_out_idx),
      .out_valid_o(b_out_valid), .out_ready_i(b_ordy)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One cycle on instance A. g is the channel the spec's arbitration must
   // grant this cycle, or -1 for no grant.
   task automatic cyc_a(input logic [5:0] v, input logic ordy, input int g);
      logic [15:0] head;
      logic [5:0]  er;
      @(negedge clk);
      a_valid = v;
      a_ordy  = ordy;
      for (int c = 0; c < 6; c++) a_data[c] = seed[c] + 8'(cnt[c]);
      #1;
      chk("a_out_valid", 32'(a_out_valid), 32'(a_full));
      if (a_full) begin
         chk("a_q_nonempty", 32'(a_q.size() != 0), 32'd1);
         if (a_q.size() != 0) begin
            head = a_q[0];
            chk("a_out_idx",  32'(a_out_idx),  32'(head[15:8]));
            chk("a_out_data", 32'(a_out_data), 32'(head[7:0]));
            if (ordy) void'(a_q.pop_front());
         end
      end
      er = (g < 0) ? 6'd0 : 6'(1 << g);
      chk("a_in_ready", 32'(a_in_ready), 32'(er));
      if (g >= 0) begin
         a_q.push_back({8'(g), a_data[g]});
         cnt[g]++;
      end
      a_full = (g >= 0) ? 1'b1 : (ordy ? 1'b0 : a_full);
   endtask

   task automatic cyc_b(input logic add_new);
      logic free;
      @(negedge clk);
      b_valid = b_valid & ~b_acc;
      for (int c = 0; c < 5; c++) begin
         if (add_new && !b_valid[c] && $urandom_range(0, 2) != 0) begin
            b_valid[c] = 1'b1;
            b_data[c]  = 12'((c << 8) | (b_cnt[c] & 255));
            b_cnt[c]++;
         end
      end
      b_ordy = add_new ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      free = !b_out_valid || b_ordy;
      chk("b_rdy_onehot0", 32'($onehot0(b_in_ready)), 32'd1);
      chk("b_rdy_subset",  32'(|(b_in_ready & ~b_valid)), 32'd0);
      chk("b_rdy_live",    32'(|b_in_ready), 32'(free && (|b_valid)));
      if (b_out_valid) begin
         chk("b_idx_range", 32'(b_out_idx < 3'd5), 32'd1);
         if (b_ordy && b_out_idx < 3'd5) begin
            chk("b_no_dup", 32'(b_q[b_out_idx].size() != 0), 32'd1);
            if (b_q[b_out_idx].size() != 0)
               chk("b_out_data", 32'(b_out_data), 32'(b_q[b_out_idx].pop_front()));
         end
      end
      b_acc = b_in_ready & b_valid;
      for (int c = 0; c < 5; c++) if (b_acc[c]) b_q[c].push_back(b_data[c]);
   endtask

   initial begin
      arst    = 1'b1;
      a_full  = 1'b0;
      a_ordy  = 1'b1;
      a_valid = 6'h3F;
      b_valid = '0;
      b_ordy  = 1'b1;
      b_acc   = '0;
      for (int c = 0; c < 6; c++) begin seed[c] = 8'(c * 32); cnt[c] = 0; end
      for (int c = 0; c < 6; c++) a_data[c] = seed[c];
      for (int c = 0; c < 5; c++) begin b_cnt[c] = 0; b_data[c] = '0; end

      // Reset with every channel requesting
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      chk("rst_out_valid", 32'(a_out_valid), 32'd0);
      chk("rst_out_data",  32'(a_out_data),  32'd0);
      chk("rst_out_idx",   32'(a_out_idx),   32'd0);
      chk("rst_in_ready",  32'(a_in_ready),  32'h01);
      chk("rst_b_valid",   32'(b_out_valid), 32'd0);
      @(posedge clk); #2;
      arst = 1'b0;

      // Fairness: 0..5 then wrap
      cyc_a(6'h3F, 1'b1, 0);
      cyc_a(6'h3F, 1'b1, 1);
      cyc_a(6'h3F, 1'b1, 2);
      cyc_a(6'h3F, 1'b1, 3);
      cyc_a(6'h3F, 1'b1, 4);
      cyc_a(6'h3F, 1'b1, 5);
      cyc_a(6'h3F, 1'b1, 0);
      cyc_a(6'h3F, 1'b1, 1);

      // Single requester: channel 3, first word 0xA5
      seed[3] = 8'hA5;
      cnt[3]  = 0;
      repeat (4) cyc_a(6'b001000, 1'b1, 3);
      cyc_a(6'b000000, 1'b1, -1);
      cyc_a(6'b000000, 1'b1, -1);

      // Park ptr at 0, then stall with channels 1 and 4
      cyc_a(6'b000001, 1'b1, 0);
      cyc_a(6'b000000, 1'b1, -1);
      cyc_a(6'b010010, 1'b0, 1);
      repeat (5) cyc_a(6'b010010, 1'b0, -1);
      cyc_a(6'b010010, 1'b1, 4);
      cyc_a(6'b010010, 1'b1, 1);

      // Wrap after channel 5
      cyc_a(6'b100000, 1'b1, 5);
      cyc_a(6'b000101, 1'b1, 0);
      cyc_a(6'b000101, 1'b1, 2);
      cyc_a(6'b000101, 1'b1, 0);

      // Reset while FULL and stalled
      cyc_a(6'b000100, 1'b1, 2);
      cyc_a(6'b000100, 1'b0, -1);
      @(negedge clk);
      a_valid = 6'b100101;
      a_ordy  = 1'b0;
      for (int c = 0; c < 6; c++) a_data[c] = seed[c] + 8'(cnt[c]);
      arst = 1'b1;
      #1;
      chk("mid_rst_out_valid", 32'(a_out_valid), 32'd0);
      chk("mid_rst_out_data",  32'(a_out_data),  32'd0);
      chk("mid_rst_in_ready",  32'(a_in_ready),  32'h01);
      a_q.delete();
      a_full = 1'b0;
      @(posedge clk); #2;
      arst = 1'b0;
      cyc_a(6'b100101, 1'b1, 0);
      cyc_a(6'b100101, 1'b1, 2);
      cyc_a(6'b100101, 1'b1, 5);
      cyc_a(6'b000000, 1'b1, -1);
      cyc_a(6'b000000, 1'b1, -1);

      // Random traffic on the 5 x 12 instance
      for (int t = 0; t < 600; t++) cyc_b(1'b1);
      for (int t = 0; t < 20; t++)  cyc_b(1'b0);
      for (int c = 0; c < 5; c++) chk("b_q_drained", 32'(b_q[c].size()), 32'd0);
      chk("b_idle_valid", 32'(b_out_valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule : tb_rr_mux
